// File: rtl/uart_echo_pkg.sv
// Shared encodings and constants for the buffered UART echo block.
package uart_echo_pkg;

    typedef enum logic [1:0] {
        MODE_ECHO  = 2'b00,
        MODE_UPPER = 2'b01,
        MODE_CRLF  = 2'b10,
        MODE_MUTE  = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_ACK,
        WAIT_DONE,
        GAP,
        LF
    } state_e;

    localparam logic [7:0]  ASCII_CR    = 8'h0D;
    localparam logic [7:0]  ASCII_LF    = 8'h0A;
    localparam int unsigned ACK_TIMEOUT = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data and an occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [DATA_W-1:0]            wdata_i,
    input  logic                         pop_i,
    output logic [DATA_W-1:0]            rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next pointer and occupancy values; pointers wrap naturally at DEPTH.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_echo_buf.sv
// Buffered UART echo: FIFO between receiver and transmitter, with optional
// uppercase / CR->CRLF transforms, lost-ack guard and inter-byte gap.
module uart_echo_buf
    import uart_echo_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned GAP_CYCLES = 50000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           rx_data,
    input  logic                        new_rx_data,
    input  logic                        tx_busy,
    input  logic [1:0]                  mode,
    input  logic                        ovf_clr,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_begin,
    output logic [$clog2(DEPTH+1)-1:0]  fifo_count,
    output logic                        overflow,
    output logic                        tx_idle
);

    localparam int unsigned ACK_W    = $clog2(ACK_TIMEOUT);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [DATA_W-1:0]   byte_q, byte_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_begin_q, tx_begin_d;
    logic [ACK_W-1:0]    ack_cnt_q, ack_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic                lf_sent_q, lf_sent_d;
    logic                overflow_q, overflow_d;

    logic                pop;
    logic                fifo_full, fifo_empty;
    logic [DATA_W-1:0]   fifo_rdata;
    logic [DATA_W-1:0]   xform;
    logic                is_cr;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .push_i  (new_rx_data),
        .wdata_i (rx_data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign tx_data  = tx_data_q;
    assign tx_begin = tx_begin_q;
    assign overflow = overflow_q;
    assign tx_idle  = fifo_empty && (state_q == IDLE);
    assign is_cr    = (DATA_W == 8) && (byte_q == DATA_W'(ASCII_CR));

    // Byte transform for the mode latched at pop time.
    always_comb begin
        xform = byte_q;
        if ((DATA_W == 8) && (mode_q == MODE_UPPER) &&
            (byte_q >= DATA_W'(8'h61)) && (byte_q <= DATA_W'(8'h7A)))
            xform = byte_q - DATA_W'(8'h20);
    end

    // Transmit FSM next-state and output decode.
    // Pops are held off while the transmitter is busy so no byte is started
    // over a frame that is still in flight.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        byte_d     = byte_q;
        tx_data_d  = tx_data_q;
        tx_begin_d = 1'b0;
        ack_cnt_d  = ack_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        lf_sent_d  = lf_sent_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    pop       = 1'b1;
                    byte_d    = fifo_rdata;
                    mode_d    = mode_e'(mode);
                    lf_sent_d = 1'b0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (mode_q == MODE_MUTE) begin
                    state_d = IDLE;
                end else if (!tx_busy) begin
                    tx_data_d  = xform;
                    tx_begin_d = 1'b1;
                    ack_cnt_d  = '0;
                    state_d    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tx_busy || (ack_cnt_q == ACK_LAST))
                    state_d = WAIT_DONE;
                else
                    ack_cnt_d = ack_cnt_q + ACK_W'(1);
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if ((mode_q == MODE_CRLF) && is_cr && !lf_sent_q) begin
                        state_d = LF;
                    end else if (GAP_CYCLES > 0) begin
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LF: begin
                tx_data_d  = DATA_W'(ASCII_LF);
                tx_begin_d = 1'b1;
                lf_sent_d  = 1'b1;
                ack_cnt_d  = '0;
                state_d    = WAIT_ACK;
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST)
                    state_d = IDLE;
                else
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky overflow: a new drop in the same cycle as a clear wins.
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_clr) overflow_d = 1'b0;
        if (new_rx_data && fifo_full && !pop) overflow_d = 1'b1;
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mode_q     <= MODE_ECHO;
            byte_q     <= '0;
            tx_data_q  <= '0;
            tx_begin_q <= 1'b0;
            ack_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            lf_sent_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            byte_q     <= byte_d;
            tx_data_q  <= tx_data_d;
            tx_begin_q <= tx_begin_d;
            ack_cnt_q  <= ack_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            lf_sent_q  <= lf_sent_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_uart_echo_buf.sv
// Directed bench for uart_echo_buf with a simple transmitter model.
module tb_uart_echo_buf;

    localparam int unsigned GAP   = 10;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic       tx_busy;
    logic [1:0] mode;
    logic       ovf_clr;
    logic [7:0] tx_data;
    logic       tx_begin;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       tx_idle;

    uart_echo_buf #(
        .DATA_W     (8),
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clock       (clk),
        .reset       (rst_n),
        .rx_data     (rx_data),
        .new_rx_data (new_rx_data),
        .tx_busy     (tx_busy),
        .mode        (mode),
        .ovf_clr     (ovf_clr),
        .tx_data     (tx_data),
        .tx_begin    (tx_begin),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .tx_idle     (tx_idle)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Transmitter model state
    logic        hold_busy = 1'b0;
    int          busy_cnt  = 0;
    int          cyc       = 0;
    int          last_fall = -1;
    logic        prev_begin = 1'b0;
    int unsigned maxc      = 0;
    logic [7:0]  cap_q [$];
    int          beg_q [$];
    int          fall_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transmitter model: busy for FRAME cycles after each start strobe.
    initial tx_busy = 1'b0;
    always @(negedge clk) begin
        logic nb;
        cyc++;
        if (tx_begin) begin
            n_checks++;
            if (prev_begin) begin
                n_fail++;
                $display("FAIL begin_consec: tx_begin high two cycles at cycle %0d", cyc);
            end
            n_checks++;
            if (tx_busy) begin
                n_fail++;
                $display("FAIL begin_while_busy: tx_begin with tx_busy=1 at cycle %0d", cyc);
            end
            cap_q.push_back(tx_data);
            beg_q.push_back(cyc);
            fall_q.push_back(last_fall);
            busy_cnt = FRAME;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        prev_begin = tx_begin;
        nb = hold_busy || (busy_cnt > 0);
        if (tx_busy && !nb) last_fall = cyc;
        tx_busy = nb;
        if (int'(fifo_count) > int'(maxc)) maxc = fifo_count;
    end

    task automatic clear_capture();
        cap_q.delete();
        beg_q.delete();
        fall_q.delete();
    endtask

    // Push n bytes on consecutive cycles.
    task automatic push_bytes(input int unsigned n, input logic [0:5][7:0] b);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            rx_data     = b[i];
            new_rx_data = 1'b1;
        end
        @(negedge clk);
        new_rx_data = 1'b0;
    endtask

    // Wait until the block and the transmitter model have both been quiet for a while.
    task automatic wait_idle(input string name);
        int stable = 0;
        for (int i = 0; i < 600 && stable < 5; i++) begin
            @(negedge clk);
            #1;
            if (tx_idle && !tx_busy) stable++;
            else stable = 0;
        end
        n_checks++;
        if (stable < 5) begin
            n_fail++;
            $display("FAIL %s_idle_timeout: got not-idle expected idle", name);
        end
    endtask

    typedef struct {
        logic [1:0]       md;
        int unsigned      n_in;
        logic [0:5][7:0]  din;
        int unsigned      n_out;
        logic [0:2][7:0]  dout;
        int unsigned      max_cnt;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [0:5][7:0] ob;

        vecs[0] = '{md: 2'b00, n_in: 1, din: {8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    n_out: 1, dout: {8'h41, 8'h00, 8'h00}, max_cnt: 1};
        vecs[1] = '{md: 2'b01, n_in: 3, din: {8'h61, 8'h7A, 8'h5B, 8'h00, 8'h00, 8'h00},
                    n_out: 3, dout: {8'h41, 8'h5A, 8'h5B}, max_cnt: 2};
        vecs[2] = '{md: 2'b10, n_in: 2, din: {8'h0D, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00},
                    n_out: 3, dout: {8'h0D, 8'h0A, 8'h42}, max_cnt: 1};
        vecs[3] = '{md: 2'b01, n_in: 3, din: {8'h60, 8'h7B, 8'h6D, 8'h00, 8'h00, 8'h00},
                    n_out: 3, dout: {8'h60, 8'h7B, 8'h4D}, max_cnt: 2};
        vecs[4] = '{md: 2'b11, n_in: 3, din: {8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00},
                    n_out: 0, dout: {8'h00, 8'h00, 8'h00}, max_cnt: 2};
        vecs[5] = '{md: 2'b10, n_in: 2, din: {8'h42, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00},
                    n_out: 3, dout: {8'h42, 8'h0D, 8'h0A}, max_cnt: 1};

        rst_n = 1'b0; rx_data = '0; new_rx_data = 1'b0; mode = 2'b00; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_data",    32'(tx_data), 32'h00);
        chk("rst_tx_begin",   32'(tx_begin), 32'h0);
        chk("rst_fifo_count", 32'(fifo_count), 32'h0);
        chk("rst_overflow",   32'(overflow), 32'h0);
        chk("rst_tx_idle",    32'(tx_idle), 32'h1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Pop latency and inter-byte gap
        clear_capture();
        @(negedge clk);
        rx_data = 8'h41; new_rx_data = 1'b1;
        @(negedge clk);
        new_rx_data = 1'b0;
        chk("push_count", 32'(fifo_count), 32'h1);
        lat = 1;
        while (!tx_begin && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("pop_latency", 32'(lat), 32'd3);
        chk("first_tx_data", 32'(tx_data), 32'h41);
        ob = '0; ob[0] = 8'h42;
        push_bytes(1, ob);
        wait_idle("gap");
        chk("gap_n_tx", 32'(cap_q.size()), 32'd2);
        if (cap_q.size() == 2) begin
            chk("gap_byte1", 32'(cap_q[1]), 32'h42);
            n_checks++;
            if (beg_q[1] - fall_q[1] < int'(GAP)) begin
                n_fail++;
                $display("FAIL gap_spacing: got %0d cycles after busy fell expected >= %0d",
                         beg_q[1] - fall_q[1], GAP);
            end
        end

        // Table-driven transform vectors
        for (int v = 0; v < 6; v++) begin
            clear_capture();
            @(negedge clk);
            mode = vecs[v].md;
            maxc = 0;
            push_bytes(vecs[v].n_in, vecs[v].din);
            wait_idle($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_n_tx", v), 32'(cap_q.size()), 32'(vecs[v].n_out));
            for (int unsigned i = 0; i < vecs[v].n_out && i < cap_q.size(); i++)
                chk($sformatf("vec%0d_tx%0d", v, i), 32'(cap_q[i]), 32'(vecs[v].dout[i]));
            chk($sformatf("vec%0d_max_count", v), 32'(maxc), 32'(vecs[v].max_cnt));
            chk($sformatf("vec%0d_count_end", v), 32'(fifo_count), 32'h0);
            chk($sformatf("vec%0d_idle_end", v), 32'(tx_idle), 32'h1);
        end

        // Overflow with transmitter held busy
        clear_capture();
        @(negedge clk);
        mode = 2'b00;
        hold_busy = 1'b1;
        repeat (2) @(negedge clk);
        ob = {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
        push_bytes(6, ob);
        chk("ovf_count", 32'(fifo_count), 32'd4);
        chk("ovf_set", 32'(overflow), 32'h1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'h0);
        rx_data = 8'hA7; new_rx_data = 1'b1; ovf_clr = 1'b1;
        @(negedge clk);
        new_rx_data = 1'b0; ovf_clr = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 32'h1);
        chk("ovf_count_full", 32'(fifo_count), 32'd4);
        chk("ovf_no_tx_busy", 32'(cap_q.size()), 32'd0);
        hold_busy = 1'b0;
        wait_idle("ovf");
        chk("ovf_n_tx", 32'(cap_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < int'(cap_q.size()); i++)
            chk($sformatf("ovf_tx%0d", i), 32'(cap_q[i]), 32'(8'hA1 + i));
        chk("ovf_sticky", 32'(overflow), 32'h1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr2", 32'(overflow), 32'h0);

        // Reset during WAIT_DONE with two bytes queued
        clear_capture();
        ob = {8'h51, 8'h52, 8'h53, 8'h00, 8'h00, 8'h00};
        push_bytes(3, ob);
        lat = 0;
        while (cap_q.size() == 0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        repeat (2) @(negedge clk);
        chk("pre_rst_count", 32'(fifo_count), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_begin", 32'(tx_begin), 32'h0);
        chk("mid_rst_count", 32'(fifo_count), 32'h0);
        chk("mid_rst_idle", 32'(tx_idle), 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_capture();
        repeat (60) @(negedge clk);
        chk("post_rst_no_tx", 32'(cap_q.size()), 32'd0);
        chk("post_rst_idle", 32'(tx_idle), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
